// File: rtl/audio_vis_pkg.sv
// Shared types and constants for the audio visualisation path: read-FSM states,
// default sample width and the dropped-sample counter width.
package audio_vis_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DROP_COUNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } rd_state_e;

  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(input logic [DROP_COUNT_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + DROP_COUNT_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/mono_sample_framer_if.sv
// AXI4-Stream bundle carrying completed frames from the framer to the FFT stage.
interface mono_sample_framer_if #(
  parameter int DATA_WIDTH = audio_vis_pkg::DEFAULT_DATA_WIDTH
);
  logic                  M_AXIS_TVALID;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport master (output M_AXIS_TVALID, output M_AXIS_TDATA, output M_AXIS_TLAST, input M_AXIS_TREADY);
  modport slave  (input M_AXIS_TVALID, input M_AXIS_TDATA, input M_AXIS_TLAST, output M_AXIS_TREADY);
endinterface

// File: rtl/framer_bank_ram.sv
// Two-bank simple dual-port sample RAM; address is {bank, idx}, read data is
// registered one cycle after the read enable and holds until the next read.
module framer_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [2*FRAME_LEN];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; held between reads so the output beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mono_sample_framer.sv
// Collects the mono sample stream into ping-pong frames and emits each as an
// AXI4-Stream burst with TLAST. Optional drop counter: FRAMER_DROP_COUNT_EN.
module mono_sample_framer
  import audio_vis_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic                  mono_sample_valid,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  mono_sample_framer_if.master  m_axis,
  output logic                  overflow
`ifdef FRAMER_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
`endif
);

  localparam int ADDR_WIDTH = $clog2(FRAME_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

  rd_state_e             state_r, state_s;
  logic [1:0]            full_r, full_s;
  logic                  fill_bank_r, rd_bank_r;
  logic [ADDR_WIDTH-1:0] wr_idx_r, rd_idx_r, rd_idx_s;
  logic                  wr_en_s, drop_s, complete_s, release_s, rd_en_s;
  logic                  tvalid_r, tlast_r, overflow_r;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign wr_en_s    = mono_sample_valid && !full_r[fill_bank_r];
  assign drop_s     = mono_sample_valid &&  full_r[fill_bank_r];
  assign complete_s = wr_en_s && (wr_idx_r == LAST_IDX);

  framer_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (M_AXIS_ACLK),
    .rst_n(M_AXIS_ARESETN),
    .we   (wr_en_s),
    .waddr({fill_bank_r, wr_idx_r}),
    .wdata(mono_sample),
    .re   (rd_en_s),
    .raddr({rd_bank_r, rd_idx_r}),
    .rdata(rdata_s)
  );

  // Read FSM next-state and control decode.
  always_comb begin
    state_s   = state_r;
    rd_idx_s  = rd_idx_r;
    rd_en_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r]) begin
          rd_idx_s = {ADDR_WIDTH{1'b0}};
          state_s  = FETCH;
        end else begin
          state_s  = IDLE;
        end
      end
      FETCH: begin
        rd_en_s = 1'b1;
        state_s = SEND;
      end
      SEND: begin
        if (!m_axis.M_AXIS_TREADY) begin
          state_s = SEND;
        end else if (rd_idx_r == LAST_IDX) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          rd_idx_s = rd_idx_r + ADDR_WIDTH'(1);
          state_s  = FETCH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Full-flag update; a bank can only be set while clear and released while set,
  // so completing one bank and releasing the other never collide.
  always_comb begin
    full_s = full_r;
    if (complete_s) begin
      full_s[fill_bank_r] = 1'b1;
    end else begin
      full_s[fill_bank_r] = full_r[fill_bank_r];
    end
    if (release_s) begin
      full_s[rd_bank_r] = 1'b0;
    end else begin
      full_s[rd_bank_r] = full_s[rd_bank_r];
    end
  end

  // Framer state registers and registered stream outputs.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_r     <= IDLE;
      full_r      <= 2'b00;
      fill_bank_r <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= {ADDR_WIDTH{1'b0}};
      rd_idx_r    <= {ADDR_WIDTH{1'b0}};
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      full_r     <= full_s;
      rd_idx_r   <= rd_idx_s;
      tvalid_r   <= (state_s == SEND);
      tlast_r    <= (state_s == SEND) && (rd_idx_s == LAST_IDX);
      overflow_r <= drop_s;
      if (release_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      if (complete_s) begin
        wr_idx_r    <= {ADDR_WIDTH{1'b0}};
        fill_bank_r <= ~fill_bank_r;
      end else if (wr_en_s) begin
        wr_idx_r <= wr_idx_r + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef FRAMER_DROP_COUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_count_r;

  // Saturating count of dropped input samples.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      drop_count_r <= {DROP_COUNT_WIDTH{1'b0}};
    end else if (drop_s) begin
      drop_count_r <= sat_inc(drop_count_r);
    end
  end

  assign drop_count = drop_count_r;
`endif

  assign m_axis.M_AXIS_TVALID = tvalid_r;
  assign m_axis.M_AXIS_TDATA  = rdata_s;
  assign m_axis.M_AXIS_TLAST  = tlast_r;
  assign overflow             = overflow_r;

endmodule

// File: tb/tb_mono_sample_framer.sv
// Scoreboard bench for mono_sample_framer with FRAME_LEN = 4; expected beats are
// queued at stimulus time and checked by an independent stream monitor.
module tb_mono_sample_framer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample = 32'd0;
  logic        overflow;
`ifdef FRAMER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int    vectors = 0;
  int    miscompares = 0;
  int    ovf_cnt = 0;
  beat_t exp_q[$];

  mono_sample_framer_if #(.DATA_WIDTH(32)) axis ();

  mono_sample_framer #(.DATA_WIDTH(32), .FRAME_LEN(4)) dut (
    .M_AXIS_ACLK      (clk),
    .M_AXIS_ARESETN   (rst_n),
    .mono_sample_valid(sample_valid),
    .mono_sample      (sample),
    .m_axis           (axis),
    .overflow         (overflow)
`ifdef FRAMER_DROP_COUNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Stream monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got data %0d last %0b, expected no beat",
                 axis.M_AXIS_TDATA, axis.M_AXIS_TLAST);
      end else begin
        e = exp_q.pop_front();
        if (axis.M_AXIS_TDATA !== e.data || axis.M_AXIS_TLAST !== e.last) begin
          miscompares++;
          $display("FAIL beat: got data %0d last %0b, expected data %0d last %0b",
                   axis.M_AXIS_TDATA, axis.M_AXIS_TLAST, e.data, e.last);
        end
      end
    end
    if (overflow) ovf_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input bit expect_out, input bit last);
    sample_valid = 1'b1;
    sample       = d;
    if (expect_out) exp_q.push_back('{data: d, last: last});
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
    end
    repeat (3) cyc();
  endtask

  task automatic wait_beat(input logic [31:0] d);
    int n = 0;
    while (!(axis.M_AXIS_TVALID && axis.M_AXIS_TDATA == d) && n < 50) begin
      cyc();
      n++;
    end
    check("wait_beat_seen", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
  endtask

  initial begin
    axis.M_AXIS_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    check("reset_tlast", {31'd0, axis.M_AXIS_TLAST}, 32'd0);
    check("reset_tdata", axis.M_AXIS_TDATA, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic frame with latency check
    axis.M_AXIS_TREADY = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b1, i == 4);
    check("lat_e0_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    cyc();
    check("lat_e1_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    cyc();
    check("lat_e2_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
    check("lat_e2_tdata", axis.M_AXIS_TDATA, 32'd1);
    check("lat_e2_tlast", {31'd0, axis.M_AXIS_TLAST}, 32'd0);
    drain();

    // Backpressure during beat 2
    for (int i = 1; i <= 4; i++) send(32'(20 + i), 1'b1, i == 4);
    wait_beat(32'd22);
    axis.M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
      check("bp_tdata", axis.M_AXIS_TDATA, 32'd22);
      check("bp_tlast", {31'd0, axis.M_AXIS_TLAST}, 32'd0);
    end
    axis.M_AXIS_TREADY = 1'b1;
    drain();

    // Ping-pong: two back-to-back frames
    ovf_cnt = 0;
    for (int i = 10; i <= 17; i++) send(32'(i), 1'b1, i == 13 || i == 17);
    drain();
    check("pingpong_no_overflow", 32'(ovf_cnt), 32'd0);

    // Overflow with both banks full
    axis.M_AXIS_TREADY = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i <= 7; i++) send(32'(i), 1'b1, i == 3 || i == 7);
    check("ovf_none_yet", {31'd0, overflow}, 32'd0);
    send(32'd8, 1'b0, 1'b0);
    check("ovf_pulse_8", {31'd0, overflow}, 32'd1);
    send(32'd9, 1'b0, 1'b0);
    check("ovf_pulse_9", {31'd0, overflow}, 32'd1);
    cyc();
    check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    check("ovf_count", 32'(ovf_cnt), 32'd2);
    check("ovf_blocked_tdata", axis.M_AXIS_TDATA, 32'd0);
`ifdef FRAMER_DROP_COUNT_EN
    check("drop_count_2", {16'd0, drop_count}, 32'd2);
`endif
    axis.M_AXIS_TREADY = 1'b1;
    drain();

    // Reset during beat 2
    for (int i = 1; i <= 4; i++) send(32'(30 + i), i == 1, 1'b0);
    wait_beat(32'd32);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    exp_q.delete();
    cyc();
    check("rst_tdata", axis.M_AXIS_TDATA, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    cyc();
    for (int i = 1; i <= 4; i++) send(32'(40 + i), 1'b1, i == 4);
    drain();

`ifdef FRAMER_DROP_COUNT_EN
    // Drop counter saturation
    axis.M_AXIS_TREADY = 1'b0;
    for (int i = 0; i <= 7; i++) send(32'(100 + i), 1'b1, i == 3 || i == 7);
    sample_valid = 1'b1;
    sample       = 32'hDEAD;
    for (int i = 0; i < 70000; i++) cyc();
    sample_valid = 1'b0;
    cyc();
    check("drop_count_sat", {16'd0, drop_count}, 32'h0000FFFF);
    axis.M_AXIS_TREADY = 1'b1;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mono_sample_framer.md
# mono_sample_framer

- Sits directly downstream of the stereo-to-mono converter.
- Collects its `mono_sample`/`mono_sample_valid` stream into fixed-length frames of `FRAME_LEN` samples.
- Frames are held in a two-bank (ping-pong) buffer, so one frame fills while the other drains.
- Completed frames are emitted as an AXI4-Stream master burst with `TLAST` on the final sample, for the FFT/visualization stage.

## Interface
- `DATA_WIDTH`, 32: mono sample width.
- `FRAME_LEN`, 256: samples per frame; power of two, ≥ 2.
- `ADDR_WIDTH`, `$clog2(FRAME_LEN)`: derived; not overridden.
- `M_AXIS_ACLK` input 1: single clock for all logic.
- `M_AXIS_ARESETN` input 1: reset, asynchronous assert, active-low.
- `mono_sample_valid` input 1: one-cycle strobe; sample present.
- `mono_sample` input `DATA_WIDTH`: sample data, valid with strobe.
- `M_AXIS_TVALID` output 1: output beat valid.
- `M_AXIS_TDATA` output `DATA_WIDTH`: output sample.
- `M_AXIS_TLAST` output 1: last beat of frame.
- `M_AXIS_TREADY` input 1: downstream ready.
- `overflow` output 1: one-cycle pulse when an input sample is dropped.
- `drop_count` output 16: dropped-sample counter; present only with `FRAMER_DROP_COUNT_EN`.

## Operation
- **Reset values:**
  - `TVALID`, `TLAST`, `overflow` = 0; `TDATA` = 0.
  - Both bank-full flags clear; fill bank = 0, read bank = 0, `wr_idx` = 0.
  - Read FSM = `IDLE`; `drop_count` = 0.
- **Write side:**
  - On `mono_sample_valid` with the fill bank's full flag clear:
    - write `mono_sample` to `fill_bank[wr_idx]`, then increment `wr_idx`;
    - on `wr_idx == FRAME_LEN-1`: set that bank's full flag, wrap `wr_idx` to 0, toggle the fill bank.
  - On `mono_sample_valid` with the fill bank's full flag set:
    - the sample is dropped and `wr_idx` is unchanged;
    - `overflow` pulses the next cycle;
    - `drop_count` increments, saturating at 0xFFFF.
- **Read FSM:**
  - `IDLE`: if the read bank's full flag is set, `rd_idx` = 0, go to `FETCH`.
  - `FETCH`: issue a synchronous RAM read of `read_bank[rd_idx]`, go to `SEND`.
  - `SEND`: `TVALID` = 1 with the registered RAM output; `TLAST` = (`rd_idx == FRAME_LEN-1`).
    - If `TREADY` is low: hold state; `TDATA`/`TLAST` stay stable.
    - If `TREADY` is high and not last: `rd_idx`++, go to `FETCH`.
    - If `TREADY` is high and last: clear the read bank's full flag, toggle the read bank, go to `IDLE`.
- **Ordering:** frames are emitted strictly in fill order; samples are emitted in arrival order.
- **Full flags** are registered. A sample arriving in the same cycle its target bank is released is dropped.
- **Releasing bank X and completing bank ~X in the same cycle** is legal; both flag updates take effect.
- **Reset mid-operation:**
  - `TVALID` drops asynchronously.
  - Partial frames and undrained frames are discarded; RAM contents are don't-care.

## Timing
- Output throughput: one beat per two clocks when `TREADY` is held high. One frame takes 2·`FRAME_LEN` cycles; the audio rate is far lower.
- Latency: let edge E capture the last sample of a frame with the read FSM in `IDLE`. `IDLE`→`FETCH` occurs at E+1 and `FETCH`→`SEND` at E+2. `TVALID` is high from E+2.
- `TVALID` never deasserts without a handshake, except under reset.
- `overflow` is a registered pulse one cycle after the dropped strobe.

## Configuration
- `FRAMER_DROP_COUNT_EN`:
  - Defined: the `drop_count` port and its 16-bit saturating counter exist.
  - Undefined: the port and counter are absent; the `overflow` pulse remains.

## Structure
- Shared package `audio_vis_pkg`:
  - read-FSM state encodings `IDLE`/`FETCH`/`SEND`;
  - the default `DATA_WIDTH`;
  - the `drop_count` width constant.
- Sub-module `framer_bank_ram`: simple dual-port RAM, 2·`FRAME_LEN` × `DATA_WIDTH`, one-cycle synchronous read. The address is {bank, idx}.

## Test plan
All scenarios use `FRAME_LEN` = 4.
- Basic frame: 4 strobes with data 1,2,3,4 and `TREADY` = 1 → beats 1,2,3,4, `TLAST` only on 4; first `TVALID` at E+2.
- Backpressure: `TREADY` = 0 for 5 cycles during beat 2 → `TVALID`, `TDATA` = 2 and `TLAST` = 0 stay stable; the stream resumes with 3,4.
- Ping-pong: 8 back-to-back strobes with data 10..17 and `TREADY` = 1 → two frames 10–13 and 14–17, two `TLAST`s, no `overflow`.
- Overflow: `TREADY` = 0 and 10 strobes with data 0..9 → frames 0–3 and 4–7 are buffered; samples 8 and 9 are dropped; two `overflow` pulses; `drop_count` = 2 when enabled. Releasing `TREADY` yields 0–3 then 4–7.
- Reset mid-frame: assert `M_AXIS_ARESETN` low during beat 2 of a frame → `TVALID` = 0 immediately. After release, a fresh 4-sample frame streams correctly from index 0.
- Saturation (macro defined): 70000 drops while blocked → `drop_count` = 0xFFFF.
